// File: rtl/riscv_muldiv.sv
// riscv_muldiv: iterative RV32/64 M-extension multiply/divide unit.
// One bit of the product or quotient is resolved per clock, so a normal
// operation spends exactly XLEN cycles in CALC. Divide-by-zero and signed
// overflow results are fixed by the ISA and can skip iteration entirely
// when FAST_SPECIAL is set.
//
// Ports:
//   clk       - clock, all state on the rising edge
//   reset     - asynchronous, active-high reset
//   in_valid  - request strobe (op/a/b valid)
//   in_ready  - unit is idle and not being killed
//   op        - RV M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a, b      - rs1 / rs2 operands
//   kill      - abort any in-flight operation and block acceptance
//   out_valid - result available (DONE state only)
//   out_ready - consumer takes the result
//   result    - operation result, held stable while out_valid
//   busy      - unit is not idle
module riscv_muldiv #(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int              CW      = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state;
  logic [2:0]          op_q;
  logic                neg_q;
  logic                spec_q;
  logic [XLEN-1:0]     spec_val_q;
  logic [XLEN-1:0]     opnd_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [CW-1:0]       cnt_q;

  logic                a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                neg_in;
  logic                special_in;
  logic [XLEN-1:0]     spec_val_in;

  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       rem_try;
  logic [XLEN-1:0]     rem_diff;
  logic                rem_ge;
  logic [2*XLEN-1:0]   acc_next;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     final_res;

  assign in_ready = (state == IDLE) && !kill;
  assign busy     = (state != IDLE);

  // Request decode: operand magnitudes, result sign and the ISA-defined
  // special cases. MUL treats both operands as unsigned since the low half
  // of the product is sign-agnostic.
  always_comb begin
    a_neg       = a[XLEN-1] && ((op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6));
    b_neg       = b[XLEN-1] && ((op == 3'd1) || (op == 3'd4) || (op == 3'd6));
    a_mag       = a_neg ? (~a + XLEN'(1)) : a;
    b_mag       = b_neg ? (~b + XLEN'(1)) : b;
    // Remainder follows the dividend; everything else follows sign product.
    neg_in      = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
    special_in  = 1'b0;
    spec_val_in = '0;
    if (op[2]) begin
      if (b == '0) begin
        special_in  = 1'b1;
        spec_val_in = op[1] ? a : '1;
      end else if (!op[0] && (a == MIN_NEG) && (b == '1)) begin
        special_in  = 1'b1;
        spec_val_in = op[1] ? '0 : a;
      end
    end
  end

  // One iteration step. Multiply: shift-add with the multiplier in the low
  // half of the accumulator. Divide: restoring division with the partial
  // remainder in the high half and quotient bits shifted into the low half.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_try  = acc_q[2*XLEN-1:XLEN-1];
    rem_ge   = rem_try >= {1'b0, opnd_q};
    rem_diff = rem_try[XLEN-1:0] - opnd_q;
    if (op_q[2]) begin
      acc_next = {(rem_ge ? rem_diff : rem_try[XLEN-1:0]), acc_q[XLEN-2:0], rem_ge};
    end else begin
      acc_next = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // Sign fix-up and result selection from the accumulator after the last step.
  always_comb begin
    prod = neg_q ? (~acc_next + (2*XLEN)'(1)) : acc_next;
    case (op_q)
      3'd0:                final_res = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    final_res = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:          final_res = neg_q ? (~acc_next[XLEN-1:0] + XLEN'(1)) : acc_next[XLEN-1:0];
      default:             final_res = neg_q ? (~acc_next[2*XLEN-1:XLEN] + XLEN'(1)) : acc_next[2*XLEN-1:XLEN];
    endcase
    if (spec_q) begin
      final_res = spec_val_q;
    end
  end

  // Control FSM plus datapath registers. Kill always wins over out_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      result     <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      op_q       <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && !kill) begin
            op_q       <= op;
            neg_q      <= neg_in;
            spec_q     <= special_in;
            spec_val_q <= spec_val_in;
            opnd_q     <= op[2] ? b_mag : a_mag;
            acc_q      <= {{XLEN{1'b0}}, (op[2] ? a_mag : b_mag)};
            cnt_q      <= '0;
            if (FAST_SPECIAL && special_in) begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= spec_val_in;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (kill) begin
            state <= IDLE;
            cnt_q <= '0;
          end else begin
            acc_q <= acc_next;
            if (cnt_q == LAST) begin
              cnt_q     <= '0;
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= final_res;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        DONE: begin
          if (kill || out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_muldiv.sv
// tb_riscv_muldiv: directed bench for riscv_muldiv (XLEN=32, FAST_SPECIAL=1).
// A behavioural model computes each expected result with plain SV arithmetic
// and a per-cycle compare process tracks the expected handshake timing.
module tb_riscv_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  riscv_muldiv #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Shared comparison helper; every check in the bench goes through here.
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour of the RV M instructions in plain arithmetic.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic        [63:0] p;
    logic signed [63:0] sp;
    logic signed [31:0] sx, sy, sr;
    logic        [31:0] r;
    sx = x;
    sy = y;
    r  = '0;
    case (o)
      3'd0: begin p = {32'd0, x} * {32'd0, y}; r = p[31:0]; end
      3'd1: begin sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}); r = sp[63:32]; end
      3'd2: begin sp = $signed({{32{x[31]}}, x}) * $signed({32'd0, y}); r = sp[63:32]; end
      3'd3: begin p = {32'd0, x} * {32'd0, y}; r = p[63:32]; end
      3'd4: begin
        if (y == 32'd0) r = 32'hFFFFFFFF;
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = x;
        else begin sr = sx / sy; r = sr; end
      end
      3'd5: r = (y == 32'd0) ? 32'hFFFFFFFF : x / y;
      3'd6: begin
        if (y == 32'd0) r = x;
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 32'd0;
        else begin sr = sx % sy; r = sr; end
      end
      default: r = (y == 32'd0) ? x : x % y;
    endcase
    return r;
  endfunction

  function automatic int modelLatency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && ((y == 32'd0) || (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF))) return 1;
    return 33;
  endfunction

  // Per-cycle compare process: mirrors the handshake at transaction level
  // (accept, latency countdown, consume/kill/reset) and checks the outputs.
  bit          trk = 1'b0;
  int          cyc = 0;
  int          exp_lat = 0;
  logic [31:0] exp_res = '0;

  always @(negedge clk) begin
    if (reset) begin
      check("cmp reset out_valid", out_valid, 0);
      check("cmp reset busy", busy, 0);
      check("cmp reset result", result, 0);
      trk = 1'b0;
    end else if (trk) begin
      cyc++;
      check($sformatf("cmp out_valid cyc%0d", cyc), out_valid, (cyc >= exp_lat));
      check($sformatf("cmp busy cyc%0d", cyc), busy, 1);
      check($sformatf("cmp in_ready cyc%0d", cyc), in_ready, 0);
      if (cyc >= exp_lat) check($sformatf("cmp result cyc%0d", cyc), result, exp_res);
      if (kill || ((cyc >= exp_lat) && out_ready)) trk = 1'b0;
    end else begin
      check("cmp idle out_valid", out_valid, 0);
      check("cmp idle busy", busy, 0);
      check("cmp idle in_ready", in_ready, !kill);
      if (in_valid && !kill) begin
        trk     = 1'b1;
        cyc     = 0;
        exp_res = model(op, a, b);
        exp_lat = modelLatency(op, a, b);
      end
    end
  end

  // Present one request for a single cycle, then scramble the operand inputs
  // so a unit that kept sampling them would be caught.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    op       = 3'($urandom_range(0, 7));
  endtask

  // Bounded wait for out_valid; lat counts edges after the accept edge.
  task automatic waitValid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
  endtask

  task automatic checkOutput(input string name, input bit use_lit, input logic [31:0] exp,
                             input int exp_l, input int hold);
    int lat;
    waitValid(lat);
    if (!out_valid) begin
      check({name, " timeout"}, 0, 1);
    end else begin
      if (use_lit) check(name, result, exp);
      if (exp_l > 0) check({name, " latency"}, lat, exp_l);
    end
    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " busy after consume"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    reset     = 1'b1;
    in_valid  = 1'b0;
    op        = 3'd0;
    a         = '0;
    b         = '0;
    kill      = 1'b0;
    out_ready = 1'b0;

    // Hand-computed vectors pin the model as well as the DUT.
    vecs.push_back('{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33});
    vecs.push_back('{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33});
    vecs.push_back('{3'd3, 32'h80000000, 32'h80000000, 32'h40000000, 33});
    vecs.push_back('{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33});
    vecs.push_back('{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
    vecs.push_back('{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33});
    vecs.push_back('{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
    vecs.push_back('{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
    vecs.push_back('{3'd4, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        33});
    vecs.push_back('{3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        33});
    vecs.push_back('{3'd5, 32'd100,      32'd7,        32'd14,       33});
    vecs.push_back('{3'd7, 32'd100,      32'd7,        32'd2,        33});
    vecs.push_back('{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
    vecs.push_back('{3'd6, 32'd5,        32'd0,        32'd5,        1});
    vecs.push_back('{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
    vecs.push_back('{3'd7, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 1});
    vecs.push_back('{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    vecs.push_back('{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1});

    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset result", result, 0);
    reset = 1'b0;
    #1;
    check("in_ready after reset", in_ready, 1);

    foreach (vecs[i]) begin
      check($sformatf("model vec%0d", i), model(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      checkOutput($sformatf("vec%0d", i), 1'b1, vecs[i].exp, vecs[i].lat, 0);
    end

    // Random operands: the compare process checks these against the model.
    for (int i = 0; i < 10; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      applyStimulus(ro, ra, rb);
      checkOutput($sformatf("rand%0d", i), 1'b0, '0, modelLatency(ro, ra, rb), 0);
    end

    $display("[TB] handshake hold");
    applyStimulus(3'd5, 32'd100, 32'd7);
    checkOutput("hold divu", 1'b1, 32'd14, 33, 10);

    $display("[TB] no accept in consume cycle");
    applyStimulus(3'd0, 32'd3, 32'd5);
    waitValid(lat);
    check("b2b first result", result, 32'd15);
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op        = 3'd0;
    a         = 32'd6;
    b         = 32'd7;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b not accepted on consume", busy, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b accepted next cycle", busy, 1);
    checkOutput("b2b second", 1'b1, 32'd42, 33, 0);

    $display("[TB] kill mid CALC");
    applyStimulus(3'd5, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill calc busy", busy, 0);
    check("kill calc out_valid", out_valid, 0);
    repeat (40) @(posedge clk);
    #1;
    check("kill calc no result", out_valid, 0);

    $display("[TB] kill in IDLE");
    @(posedge clk); #1;
    kill     = 1'b1;
    in_valid = 1'b1;
    op       = 3'd0;
    a        = 32'd2;
    b        = 32'd3;
    #1;
    check("kill idle in_ready", in_ready, 0);
    @(posedge clk); #1;
    check("kill idle not accepted", busy, 0);
    kill     = 1'b0;
    in_valid = 1'b0;

    $display("[TB] kill beats out_ready");
    applyStimulus(3'd0, 32'd2, 32'd3);
    waitValid(lat);
    check("kill done result", result, 32'd6);
    @(posedge clk); #1;
    kill      = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    kill      = 1'b0;
    out_ready = 1'b0;
    check("kill done busy", busy, 0);
    check("kill done out_valid", out_valid, 0);

    $display("[TB] reset mid CALC");
    applyStimulus(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("async reset out_valid", out_valid, 0);
    check("async reset busy", busy, 0);
    check("async reset result", result, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("post reset in_ready", in_ready, 1);

    applyStimulus(3'd0, 32'd7, 32'hFFFFFFFD);
    checkOutput("recover mul", 1'b1, 32'hFFFFFFEB, 33, 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
